scan_mux: RTL and testbench

- Parametrised, registered N-channel signed multiplexer for the perceptron datapath.
- Generalises the fixed 2-/3-input combinational muxes to CHANNELS inputs of WIDTH bits.
- Two operating modes:
  - Manual: registered select.
  - Scan: on a start pulse, streams every channel in order, one per cycle, so inputs and weights can be fed serially to the MAC stage.

---
 rtl/scan_mux.sv | 115 +++++++++++
 tb/tb_scan_mux.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// Registered N-channel signed mux with manual select and serial scan mode.
// Optional build macro SCAN_MUX_CONT_EN: gapless back-to-back scans while start stays high.
//
// state  | meaning
// S_IDLE | manual select (mode=0) or waiting for a scan start (mode=1)
// S_SCAN | emitting channel idx, one channel per cycle
module scan_mux #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 3,
    parameter int SEL_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*WIDTH-1:0]    in_bus,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         start,
    output logic signed [WIDTH-1:0]      out,
    output logic                         out_valid,
    output logic [SEL_W-1:0]             cur_sel,
    output logic                         busy,
    output logic                         last
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

    logic [0:0]              state;
    logic [SEL_W-1:0]        idx;
    logic signed [WIDTH-1:0] ch [CHANNELS];
    logic signed [WIDTH-1:0] man_val;
    logic                    man_hit;
    logic signed [WIDTH-1:0] scan_val;
    logic                    cont_go;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign ch[g] = in_bus[g*WIDTH +: WIDTH];
    end

    // Loop-based decode keeps out-of-range selects from indexing past the array.
    always_comb begin
        man_val  = '0;
        man_hit  = 1'b0;
        scan_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                man_val = ch[i];
                man_hit = 1'b1;
            end
            if (idx == SEL_W'(i)) begin
                scan_val = ch[i];
            end
        end
    end

`ifdef SCAN_MUX_CONT_EN
    assign cont_go = start & mode;
`else
    assign cont_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            cur_sel   <= '0;
            busy      <= 1'b0;
            last      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    last <= 1'b0;
                    if (!mode) begin
                        out       <= man_hit ? man_val : '0;
                        cur_sel   <= sel;
                        out_valid <= man_hit;
                    end else if (start) begin
                        state     <= S_SCAN;
                        idx       <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b0;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                S_SCAN: begin
                    out       <= scan_val;
                    cur_sel   <= idx;
                    out_valid <= 1'b1;
                    if (idx == LAST_IDX) begin
                        last <= 1'b1;
                        idx  <= '0;
                        if (!cont_go) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        last <= 1'b0;
                        idx  <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: per-cycle model comparison plus literal spot checks.
// Honours SCAN_MUX_CONT_EN the same way the design does.
module tb_scan_mux;

    localparam int WIDTH    = 3;
    localparam int CHANNELS = 3;
    localparam int SEL_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic                      start;
    logic signed [WIDTH-1:0]   out;
    logic                      out_valid;
    logic [SEL_W-1:0]          cur_sel;
    logic                      busy;
    logic                      last;

    int n_checks = 0;
    int n_errors = 0;

    scan_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .in_bus(in_bus), .mode(mode), .sel(sel),
        .start(start), .out(out), .out_valid(out_valid), .cur_sel(cur_sel),
        .busy(busy), .last(last)
    );

    always #5 clk = ~clk;

    // Behavioural model: "remaining" counts channels still to be emitted in the current pass.
    int m_out, m_valid, m_cur, m_busy, m_last;
    int remaining   = 0;
    bit model_ready = 1'b0;
    bit cont_en;

    function automatic int ch_val(int i);
        return int'((in_bus >> (i * WIDTH)) & ((1 << WIDTH) - 1));
    endfunction

    always @(posedge clk) begin
        model_ready = 1'b1;
        if (rst) begin
            remaining = 0;
            m_out = 0; m_valid = 0; m_cur = 0; m_busy = 0; m_last = 0;
        end else if (remaining > 0) begin
            m_out     = ch_val(CHANNELS - remaining);
            m_cur     = CHANNELS - remaining;
            m_valid   = 1;
            remaining = remaining - 1;
            m_last    = (remaining == 0) ? 1 : 0;
            if (remaining == 0 && cont_en && start && mode) remaining = CHANNELS;
            m_busy = (remaining > 0) ? 1 : 0;
        end else if (!mode) begin
            m_last = 0;
            m_cur  = int'(sel);
            if (int'(sel) < CHANNELS) begin
                m_out = ch_val(int'(sel)); m_valid = 1;
            end else begin
                m_out = 0; m_valid = 0;
            end
        end else begin
            m_valid = 0;
            m_last  = 0;
            if (start) begin
                remaining = CHANNELS;
                m_busy    = 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            chk("model.out",       int'(unsigned'(out)), m_out);
            chk("model.out_valid", int'(out_valid),      m_valid);
            chk("model.cur_sel",   int'(cur_sel),        m_cur);
            chk("model.busy",      int'(busy),           m_busy);
            chk("model.last",      int'(last),           m_last);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
`ifdef SCAN_MUX_CONT_EN
        cont_en = 1'b1;
`else
        cont_en = 1'b0;
`endif
        in_bus = {3'b111, 3'b010, 3'b101};
        rst = 1'b1; mode = 1'b1; start = 1'b1; sel = '0;

        // Reset held with scan request present
        step(); step();
        chk("rst.out", int'(unsigned'(out)), 0);
        chk("rst.busy", int'(busy), 0);
        rst = 1'b0; start = 1'b0;
        step();
        chk("rst_rel.valid", int'(out_valid), 0);
        chk("rst_rel.last", int'(last), 0);

        // Manual selection, including out-of-range select
        mode = 1'b0;
        sel = 2'd0; step(); chk("man0.out", int'(unsigned'(out)), 5);
        sel = 2'd1; step(); chk("man1.out", int'(unsigned'(out)), 2);
        sel = 2'd2; step(); chk("man2.out", int'(unsigned'(out)), 7);
        chk("man2.cur_sel", int'(cur_sel), 2);
        sel = 2'd3; step(); chk("man3.out", int'(unsigned'(out)), 0);
        chk("man3.valid", int'(out_valid), 0);

        // Plain scan
        mode = 1'b1; start = 1'b1; step();
        chk("scan.E0.busy", int'(busy), 1);
        start = 1'b0;
        step(); chk("scan.E1.out", int'(unsigned'(out)), 5);
        step(); chk("scan.E2.out", int'(unsigned'(out)), 2);
        step(); chk("scan.E3.out", int'(unsigned'(out)), 7);
        chk("scan.E3.last", int'(last), 1);
        chk("scan.E3.busy", int'(busy), 0);
        step();

        // Inputs changed mid-scan are ignored until back in IDLE
        start = 1'b1; step();
        start = 1'b0; mode = 1'b0; sel = 2'd2;
        step(); chk("ign.E1.out", int'(unsigned'(out)), 5);
        start = 1'b1;
        step(); chk("ign.E2.out", int'(unsigned'(out)), 2);
        step(); chk("ign.E3.last", int'(last), 1);
        start = 1'b0;
        step(); chk("ign.manual.out", int'(unsigned'(out)), 7);
        chk("ign.manual.valid", int'(out_valid), 1);

        // Reset at E2 aborts the scan
        mode = 1'b1; start = 1'b1; step();
        start = 1'b0; step();
        rst = 1'b1; step();
        chk("abort.out", int'(unsigned'(out)), 0);
        chk("abort.busy", int'(busy), 0);
        rst = 1'b0; step();
        chk("abort.last", int'(last), 0);

        // Continuous start request for 8 cycles
        start = 1'b1; mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 4) chk("cont.E4.valid", int'(out_valid), cont_en ? 1 : 0);
        end
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // in_bus change mid-scan only affects channels not yet emitted
        start = 1'b1; step();
        start = 1'b0; step();
        in_bus = {3'b011, 3'b100, 3'b101};
        step(); chk("live.E2.out", int'(unsigned'(out)), 4);
        step(); chk("live.E3.out", int'(unsigned'(out)), 3);
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
